// File: rtl/pipelined_register_file.sv
// Register file with three combinational read ports and two prioritised write ports.
// A dedicated PC register supports load, write and auto-increment, plus optional same-cycle forwarding.
module pipelined_register_file #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 4,
  parameter int                 PC_IDX   = (1 << ADDR_W) - 1,
  parameter logic [DATA_W-1:0]  PC_STEP  = 4,
  parameter logic [DATA_W-1:0]  RESET_PC = '0,
  parameter bit                 BYPASS   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  input  logic [ADDR_W-1:0] SD,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PD,
  input  logic [ADDR_W-1:0] C,
  input  logic [DATA_W-1:0] PW,
  input  logic              RFLd,
  input  logic [ADDR_W-1:0] C2,
  input  logic [DATA_W-1:0] PW2,
  input  logic              RFLd2,
  input  logic [DATA_W-1:0] PCin,
  input  logic              PCLd,
  input  logic              PCInc,
  output logic [DATA_W-1:0] PCout
);

  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_SEL = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == PC_IDX) ? RESET_PC : '0;
      end
    end else begin
      // general registers: port 0 wins a collision
      for (int i = 0; i < DEPTH; i++) begin
        if (i != PC_IDX) begin
          if (RFLd && (C == ADDR_W'(i))) begin
            regs[i] <= PW;
          end else if (RFLd2 && (C2 == ADDR_W'(i))) begin
            regs[i] <= PW2;
          end
        end
      end
      // PC: branch load beats register writes, which beat the increment
      if (PCLd) begin
        regs[PC_IDX] <= PCin;
      end else if (RFLd && (C == PC_SEL)) begin
        regs[PC_IDX] <= PW;
      end else if (RFLd2 && (C2 == PC_SEL)) begin
        regs[PC_IDX] <= PW2;
      end else if (PCInc) begin
        regs[PC_IDX] <= regs[PC_IDX] + PC_STEP;
      end
    end
  end

  // Forwarding only sees the write ports; PC load/increment are never visible early.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] sel);
    logic [DATA_W-1:0] val;
    val = regs[sel];
    if (BYPASS && !RST) begin
      if (RFLd && (C == sel)) begin
        val = PW;
      end else if (RFLd2 && (C2 == sel)) begin
        val = PW2;
      end
    end
    return val;
  endfunction

  always_comb begin
    PA = read_port(SA);
    PB = read_port(SB);
    PD = read_port(SD);
  end

  assign PCout = regs[PC_IDX];

endmodule

// File: tb/tb_pipelined_register_file.sv
// Bench for pipelined_register_file: bypassed and non-bypassed instances share stimulus and are
// checked each cycle against an array model, plus literal expectations from directed scenarios.
module tb_pipelined_register_file;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int PCI = 15;
  localparam logic [DW-1:0] RPC = '0;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] SA = '0, SB = '0, SD = '0, C = '0, C2 = '0;
  logic [DW-1:0] PW = '0, PW2 = '0, PCin = '0;
  logic          RFLd = 1'b0, RFLd2 = 1'b0, PCLd = 1'b0, PCInc = 1'b0;
  logic [DW-1:0] PA_b, PB_b, PD_b, PC_b;
  logic [DW-1:0] PA_n, PB_n, PD_n, PC_n;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m [16];
  bit            model_valid = 1'b0;

  always #5 CLK = ~CLK;

  pipelined_register_file #(.DATA_W(DW), .ADDR_W(AW), .PC_IDX(PCI), .PC_STEP(4),
                            .RESET_PC(RPC), .BYPASS(1'b1)) u_byp (
    .CLK(CLK), .RST(RST), .SA(SA), .SB(SB), .SD(SD), .PA(PA_b), .PB(PB_b), .PD(PD_b),
    .C(C), .PW(PW), .RFLd(RFLd), .C2(C2), .PW2(PW2), .RFLd2(RFLd2),
    .PCin(PCin), .PCLd(PCLd), .PCInc(PCInc), .PCout(PC_b));

  pipelined_register_file #(.DATA_W(DW), .ADDR_W(AW), .PC_IDX(PCI), .PC_STEP(4),
                            .RESET_PC(RPC), .BYPASS(1'b0)) u_nobyp (
    .CLK(CLK), .RST(RST), .SA(SA), .SB(SB), .SD(SD), .PA(PA_n), .PB(PB_n), .PD(PD_n),
    .C(C), .PW(PW), .RFLd(RFLd), .C2(C2), .PW2(PW2), .RFLd2(RFLd2),
    .PCin(PCin), .PCLd(PCLd), .PCInc(PCInc), .PCout(PC_n));

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // What a read port must show: latest write-port data for that index if forwarding, else storage.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] sel, input bit byp);
    if (byp && !RST && RFLd && C == sel) return PW;
    if (byp && !RST && RFLd2 && C2 == sel) return PW2;
    return m[sel];
  endfunction

  // Model: apply one clock edge to the architectural register array.
  always @(posedge CLK) begin
    if (RST) begin
      foreach (m[i]) m[i] = '0;
      m[PCI] = RPC;
      model_valid = 1'b1;
    end else if (model_valid) begin
      logic [DW-1:0] pc_next;
      if (PCLd)                         pc_next = PCin;
      else if (RFLd && C == PCI)        pc_next = PW;
      else if (RFLd2 && C2 == PCI)      pc_next = PW2;
      else if (PCInc)                   pc_next = m[PCI] + 32'd4;
      else                              pc_next = m[PCI];
      if (RFLd2 && C2 != PCI) m[C2] = PW2;
      if (RFLd && C != PCI)   m[C] = PW;
      m[PCI] = pc_next;
    end
  end

  always @(negedge CLK) begin
    if (model_valid) begin
      check("byp_PA", PA_b, exp_rd(SA, 1'b1));
      check("byp_PB", PB_b, exp_rd(SB, 1'b1));
      check("byp_PD", PD_b, exp_rd(SD, 1'b1));
      check("byp_PCout", PC_b, m[PCI]);
      check("nobyp_PA", PA_n, exp_rd(SA, 1'b0));
      check("nobyp_PB", PB_n, exp_rd(SB, 1'b0));
      check("nobyp_PD", PD_n, exp_rd(SD, 1'b0));
      check("nobyp_PCout", PC_n, m[PCI]);
    end
  end

  task automatic idle();
    RST = 1'b0; RFLd = 1'b0; RFLd2 = 1'b0; PCLd = 1'b0; PCInc = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [DW-1:0] v;
    // reset
    tick(); tick();
    idle();
    SA = 4'd0; SB = 4'd15; SD = 4'd7;
    #1;
    check("rst_PA", PA_b, 32'd0);
    check("rst_PB_pc", PB_b, RPC);
    check("rst_PCout", PC_b, RPC);

    // fill and readback
    for (int i = 0; i < 15; i++) begin
      RFLd = 1'b1; C = AW'(i); PW = DW'(i * 3 + 1); SA = AW'(i);
      #1 check("fill_bypass", PA_b, DW'(i * 3 + 1));
      tick();
    end
    idle();
    for (int i = 0; i < 15; i++) begin
      SA = AW'(i); SB = AW'(i); SD = AW'(i);
      #1;
      check("sweep_PA", PA_n, DW'(i * 3 + 1));
      check("sweep_PD", PD_b, DW'(i * 3 + 1));
      check("sweep_PCout", PC_n, 32'd0);
    end

    // dual-write collision
    RFLd = 1'b1; RFLd2 = 1'b1; C = 4'd5; C2 = 4'd5; PW = 32'hAAAA; PW2 = 32'h5555;
    tick(); idle();
    RFLd2 = 1'b1; C2 = 4'd6; PW2 = 32'h5555;
    tick(); idle();
    SA = 4'd5; SB = 4'd6;
    #1;
    check("collide_R5", PA_n, 32'hAAAA);
    check("port1_R6", PB_n, 32'h5555);

    // bypass
    RFLd = 1'b1; C = 4'd3; PW = 32'd7;
    tick(); idle();
    RFLd = 1'b1; C = 4'd3; PW = 32'd90; SA = 4'd3;
    #1;
    check("bypass_on_pre", PA_b, 32'd90);
    check("bypass_off_pre", PA_n, 32'd7);
    tick(); idle();
    check("bypass_off_post", PA_n, 32'd90);

    // PC priority and wrap
    for (int k = 1; k <= 3; k++) begin
      PCInc = 1'b1;
      tick(); idle();
      check("pc_inc", PC_b, DW'(4 * k));
    end
    PCLd = 1'b1; PCin = 32'd100; PCInc = 1'b1; RFLd = 1'b1; C = 4'd15; PW = 32'd35;
    tick(); idle();
    check("pc_load_prio", PC_n, 32'd100);
    PCLd = 1'b1; PCin = 32'hFFFF_FFFC;
    tick(); idle();
    PCInc = 1'b1;
    tick(); idle();
    check("pc_wrap", PC_b, 32'd0);
    RFLd2 = 1'b1; C2 = 4'd15; PW2 = 32'd500; PCInc = 1'b1;
    tick(); idle();
    check("pc_port1_over_inc", PC_b, 32'd500);

    // mid-operation reset
    PCLd = 1'b1; PCin = 32'd200;
    tick(); idle();
    RST = 1'b1; RFLd = 1'b1; C = 4'd10; PW = 32'd16; PCInc = 1'b1; SA = 4'd10;
    #1 check("rst_no_bypass", PA_b, 32'd31);
    tick(); idle();
    check("midrst_R10", PA_b, 32'd0);
    check("midrst_PCout", PC_n, RPC);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      RST   = ($urandom_range(0, 49) == 0);
      SA    = AW'($urandom); SB = AW'($urandom); SD = AW'($urandom);
      C     = ($urandom_range(0, 5) == 0) ? AW'(PCI) : AW'($urandom);
      C2    = ($urandom_range(0, 3) == 0) ? C : AW'($urandom);
      v     = $urandom;
      PW    = v;
      PW2   = $urandom;
      PCin  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      RFLd  = $urandom_range(0, 1) == 1;
      RFLd2 = $urandom_range(0, 1) == 1;
      PCLd  = $urandom_range(0, 7) == 0;
      PCInc = $urandom_range(0, 1) == 1;
      tick();
    end
    idle();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timed out");
  end

endmodule
